// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message sequencer and compression core.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PAD   = 3'd2,
        S_ZERO  = 3'd3,
        S_LEN   = 3'd4,
        S_ISSUE = 3'd5,
        S_WAIT  = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET  = 56;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Initial hash value H0..H7, H0 in the most significant word.
    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte message block register: byte writes, length-field write, flat output.
// Byte 0 sits in the most significant byte of the flat output.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [5:0]   wr_idx,
    input  logic [7:0]   wr_data,
    input  logic         len_en,
    input  logic [63:0]  len_val,
    output logic [511:0] block
);

    localparam int LEN_BITS = 8 * (BLOCK_BYTES - LEN_OFFSET);

    logic [511:0] blk_q;
    logic [511:0] blk_d;

    // Next buffer contents: clear wins, otherwise apply byte and/or length writes.
    always_comb begin
        blk_d = blk_q;
        if (clr) begin
            blk_d = '0;
        end else begin
            if (wr_en) begin
                blk_d[(BLOCK_BYTES - 1 - int'(wr_idx)) * 8 +: 8] = wr_data;
            end
            if (len_en) begin
                blk_d[LEN_BITS-1:0] = len_val;
            end
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign block = blk_q;

endmodule

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message sequencer: packs a byte stream into 512-bit blocks, appends
// padding and bit length, and drives the compression core block by block.
module sha256_msg_ctrl
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_start,
    output logic         core_first,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic [255:0] hash_out,
    output logic         hash_valid,
    output logic         busy
);

    localparam logic [6:0] LAST_DATA = 7'(LEN_OFFSET - 1);
    localparam logic [6:0] LAST_SLOT = 7'(BLOCK_BYTES - 1);

    state_e             state_q, state_d;
    state_e             ret_state_q, ret_state_d;
    logic [6:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               first_blk_q, first_blk_d;
    logic               final_blk_q, final_blk_d;
    logic [255:0]       hash_out_q, hash_out_d;
    logic               hash_valid_q, hash_valid_d;
    logic               core_start_q, core_start_d;
    logic               core_first_q, core_first_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               buf_clr;
    logic               buf_wr_en;
    logic [7:0]         buf_wr_data;
    logic               buf_len_en;
    logic [63:0]        len_val;

    assign accept  = in_valid && in_ready_q;
    // Message length in bits; zero-extended into the 64-bit length field.
    assign len_val = 64'({byte_cnt_q, 3'b000});

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        idx_d        = idx_q;
        byte_cnt_d   = byte_cnt_q;
        first_blk_d  = first_blk_q;
        final_blk_d  = final_blk_q;
        hash_out_d   = hash_out_q;
        buf_clr      = 1'b0;
        buf_wr_en    = 1'b0;
        buf_wr_data  = in_data;
        buf_len_en   = 1'b0;

        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    buf_wr_en  = 1'b1;
                    idx_d      = idx_q + 7'd1;
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    if (idx_q == LAST_SLOT) begin
                        // Block full: issue it, then resume filling or start padding.
                        state_d     = S_ISSUE;
                        ret_state_d = in_last ? S_PAD : S_FILL;
                    end else if (in_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_PAD: begin
                buf_wr_en   = 1'b1;
                buf_wr_data = PAD_BYTE;
                idx_d       = idx_q + 7'd1;
                if (idx_q == LAST_DATA) begin
                    state_d = S_LEN;
                end else if (idx_q == LAST_SLOT) begin
                    // Marker took the last slot; the length goes in a fresh zero block.
                    state_d     = S_ISSUE;
                    ret_state_d = S_ZERO;
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                buf_wr_en   = 1'b1;
                buf_wr_data = 8'h00;
                idx_d       = idx_q + 7'd1;
                if (idx_q == LAST_DATA) begin
                    state_d = S_LEN;
                end else if (idx_q == LAST_SLOT) begin
                    // Overflow block: no room for the length, continue zero fill next block.
                    state_d     = S_ISSUE;
                    ret_state_d = S_ZERO;
                end
            end
            S_LEN: begin
                buf_len_en  = 1'b1;
                final_blk_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    first_blk_d = 1'b0;
                    idx_d       = 7'd0;
                    if (final_blk_q) begin
                        hash_out_d = core_digest;
                        state_d    = S_DONE;
                    end else begin
                        state_d = ret_state_q;
                    end
                end
            end
            S_DONE: begin
                byte_cnt_d  = '0;
                first_blk_d = 1'b1;
                final_blk_d = 1'b0;
                buf_clr     = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        core_start_d = (state_d == S_ISSUE);
        core_first_d = (state_d == S_ISSUE) && first_blk_q;
        hash_valid_d = (state_q == S_DONE);
        in_ready_d   = (state_d == S_IDLE) || (state_d == S_FILL);
        busy_d       = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs; reset aborts any message in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ret_state_q  <= S_FILL;
            idx_q        <= 7'd0;
            byte_cnt_q   <= '0;
            first_blk_q  <= 1'b1;
            final_blk_q  <= 1'b0;
            hash_out_q   <= '0;
            hash_valid_q <= 1'b0;
            core_start_q <= 1'b0;
            core_first_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_state_q  <= ret_state_d;
            idx_q        <= idx_d;
            byte_cnt_q   <= byte_cnt_d;
            first_blk_q  <= first_blk_d;
            final_blk_q  <= final_blk_d;
            hash_out_q   <= hash_out_d;
            hash_valid_q <= hash_valid_d;
            core_start_q <= core_start_d;
            core_first_q <= core_first_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    sha256_block_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr_en),
        .wr_idx  (idx_q[5:0]),
        .wr_data (buf_wr_data),
        .len_en  (buf_len_en),
        .len_val (len_val),
        .block   (core_block)
    );

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_first = core_first_q;
    assign hash_out   = hash_out_q;
    assign hash_valid = hash_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Scoreboard bench for sha256_msg_ctrl with a behavioural SHA-256 core model.
module tb_sha256_msg_ctrl;
    import sha256_pkg::*;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         core_start;
    logic         core_first;
    logic [511:0] core_block;
    logic         core_done;
    logic [255:0] core_digest;
    logic [255:0] hash_out;
    logic         hash_valid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_blk_q[$];
    bit           exp_first_q[$];
    logic [255:0] exp_dig_q[$];
    logic [7:0]   cur_msg[$];

    int core_lat  = 0;
    int stray_req = 0;
    int stray_ack = 0;

    always #5 clk = ~clk;

    sha256_msg_ctrl #(.LEN_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .core_start  (core_start),
        .core_first  (core_first),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_digest (core_digest),
        .hash_out    (hash_out),
        .hash_valid  (hash_valid),
        .busy        (busy)
    );

    // ---------------- reference SHA-256 ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
    endfunction

    // Standard padding of cur_msg, queued as expected blocks plus final digest.
    task automatic expect_msg(input bit use_known, input logic [255:0] known);
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [255:0] h;
        p = cur_msg;
        bitlen = 64'(cur_msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        h = SHA256_IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*bi + j];
            exp_blk_q.push_back(blk);
            exp_first_q.push_back(bi == 0);
            h = compress(h, blk);
        end
        exp_dig_q.push_back(use_known ? known : h);
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core model ----------------
    initial begin
        logic [255:0] st;
        int lat;
        core_done   = 1'b0;
        core_digest = '0;
        st = SHA256_IV;
        forever begin
            @(posedge clk);
            #1;
            if (core_start) begin
                st  = compress(core_first ? SHA256_IV : st, core_block);
                lat = (core_lat != 0) ? core_lat : int'($urandom_range(1, 6));
                repeat (lat) @(posedge clk);
                @(negedge clk);
                core_digest = st;
                core_done   = 1'b1;
                @(negedge clk);
                core_done   = 1'b0;
                core_digest = {8{$urandom}};
            end else if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                @(negedge clk);
                core_digest = {8{$urandom}};
                core_done   = 1'b1;
                @(negedge clk);
                core_done   = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit           prev_rst = 1'b1;
        bit           in_flight = 1'b0;
        bit           rdy_viol = 1'b0;
        bit           acc_last;
        int           pend = 0;
        logic [511:0] eb;
        bit           ef;
        logic [255:0] ed;
        forever begin
            @(posedge clk);
            acc_last = in_valid && in_ready && in_last && !reset;
            #1;
            if (reset) begin
                chk("rst_in_ready", in_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_hash_valid", hash_valid, 0);
                chk("rst_core_start", core_start, 0);
                chk("rst_core_first", core_first, 0);
                chk("rst_hash_out", hash_out, 0);
                chk("rst_core_block", core_block, 0);
                exp_blk_q.delete();
                exp_first_q.delete();
                exp_dig_q.delete();
                in_flight = 1'b0;
                rdy_viol  = 1'b0;
                pend      = 0;
            end else begin
                if (prev_rst) begin
                    chk("idle_in_ready", in_ready, 1);
                    chk("idle_busy", busy, 0);
                end
                if (acc_last) in_flight = 1'b1;
                if (in_flight && !hash_valid && (in_ready || !busy)) rdy_viol = 1'b1;
                if (core_start) begin
                    if (exp_blk_q.size() == 0) begin
                        chk("unexpected_core_start", 1, 0);
                    end else begin
                        eb = exp_blk_q.pop_front();
                        ef = exp_first_q.pop_front();
                        chk("core_block", core_block, eb);
                        chk("core_first", core_first, ef);
                    end
                end
                if (hash_valid) begin
                    if (exp_dig_q.size() == 0) begin
                        chk("unexpected_hash_valid", 1, 0);
                    end else begin
                        ed = exp_dig_q.pop_front();
                        chk("hash_out", hash_out, ed);
                        chk("block_count", exp_blk_q.size(), 0);
                        chk("ready_low_until_done", rdy_viol, 0);
                    end
                    in_flight = 1'b0;
                    rdy_viol  = 1'b0;
                end
                if (exp_dig_q.size() != 0) pend++;
                else pend = 0;
                if (pend > 4000) begin
                    chk("digest_timeout", 1, 0);
                    exp_blk_q.delete();
                    exp_first_q.delete();
                    exp_dig_q.delete();
                    pend = 0;
                end
            end
            prev_rst = reset;
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_msg(input int n);
        cur_msg.delete();
        for (int i = 0; i < n; i++) cur_msg.push_back(8'($urandom));
    endtask

    task automatic abc_msg();
        cur_msg.delete();
        cur_msg.push_back(8'h61);
        cur_msg.push_back(8'h62);
        cur_msg.push_back(8'h63);
    endtask

    task automatic send_msg(input bit gaps, input int stray_at);
        int t;
        for (int i = 0; i < cur_msg.size(); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            if (i == stray_at) stray_req++;
            in_data  = cur_msg[i];
            in_last  = (i == cur_msg.size() - 1);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_dig_q.size() != 0 || busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    initial begin
        int t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        abc_msg();    expect_msg(1'b1, ABC_DIGEST); send_msg(1'b0, -1); wait_idle();
        rand_msg(55); expect_msg(1'b0, '0);         send_msg(1'b0, -1); wait_idle();
        rand_msg(56); expect_msg(1'b0, '0);         send_msg(1'b0, -1); wait_idle();
        rand_msg(64); expect_msg(1'b0, '0);         send_msg(1'b0, -1); wait_idle();
        rand_msg(100); expect_msg(1'b0, '0);        send_msg(1'b1, 30); wait_idle();

        // Abort during WAIT; the late core_done must not complete anything.
        core_lat = 30;
        abc_msg(); expect_msg(1'b1, ABC_DIGEST); send_msg(1'b0, -1);
        t = 0;
        while (exp_blk_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        core_lat = 0;
        abc_msg(); expect_msg(1'b1, ABC_DIGEST); send_msg(1'b0, -1); wait_idle();

        for (int m = 0; m < 6; m++) begin
            rand_msg(int'($urandom_range(1, 180)));
            expect_msg(1'b0, '0);
            send_msg(1'($urandom_range(0, 1)), -1);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
